// File: rtl/dpram_access_ctrl.sv
// Round-robin access controller that drives one dual-port RAM command at a time
// on behalf of two req/ack clients and returns read data with a valid strobe.
module dpram_access_ctrl #(
  parameter int AW     = 5,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          b_rvalid,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data_in,
  output logic          ram_wr_en,
  output logic          ram_a_enb,
  output logic          ram_b_enb,
  input  logic [DW-1:0] ram_dout_a,
  input  logic [DW-1:0] ram_dout_b
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t     state;
  logic       sel_b;
  logic       sel_we;
  logic       last_b;
  logic [1:0] cnt;
  logic       pick_b;

  // On a tie, the client that did not win last time is picked.
  assign pick_b = b_req && !(a_req && last_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel_b       <= 1'b0;
      sel_we      <= 1'b0;
      last_b      <= 1'b1;
      cnt         <= 2'd0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      a_rvalid    <= 1'b0;
      b_rvalid    <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
      ram_wr_en   <= 1'b0;
      ram_a_enb   <= 1'b0;
      ram_b_enb   <= 1'b0;
    end else begin
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      ram_wr_en <= 1'b0;
      ram_a_enb <= 1'b0;
      ram_b_enb <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            sel_b       <= pick_b;
            last_b      <= pick_b;
            sel_we      <= pick_b ? b_we : a_we;
            ram_addr    <= pick_b ? b_addr : a_addr;
            ram_data_in <= pick_b ? b_wdata : a_wdata;
            ram_wr_en   <= pick_b ? b_we : a_we;
            ram_a_enb   <= !pick_b;
            ram_b_enb   <= pick_b;
            a_ack       <= !pick_b;
            b_ack       <= pick_b;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (sel_we) begin
            state <= IDLE;
          end else begin
            cnt   <= CNT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          // The last WAIT cycle is the one where the RAM output is valid.
          if (cnt == 2'd0) begin
            if (sel_b) begin
              b_rdata  <= ram_dout_b;
              b_rvalid <= 1'b1;
            end else begin
              a_rdata  <= ram_dout_a;
              a_rvalid <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_access_ctrl.sv
// Directed bench for dpram_access_ctrl with a behavioural 1-cycle-latency
// dual-port RAM attached to the controller's RAM side.
module tb_dpram_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [4:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_ack, a_rvalid, b_ack, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic [4:0] ram_addr;
  logic [7:0] ram_data_in;
  logic       ram_wr_en, ram_a_enb, ram_b_enb;
  logic [7:0] ram_dout_a = 8'h00;
  logic [7:0] ram_dout_b = 8'h00;

  logic [7:0] mem [32];

  int checks = 0;
  int errors = 0;
  int b_enb_cnt = 0;
  int b_rvalid_cnt = 0;
  int both_ack_cnt = 0;

  logic       got_ack;
  logic [4:0] snap_addr;
  logic [7:0] snap_data;
  logic       snap_wr, snap_aenb, snap_benb, snap_oack;

  dpram_access_ctrl #(.AW(5), .DW(8), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_wr_en(ram_wr_en),
    .ram_a_enb(ram_a_enb), .ram_b_enb(ram_b_enb),
    .ram_dout_a(ram_dout_a), .ram_dout_b(ram_dout_b)
  );

  always #5 clk = ~clk;

  // RAM model: write on enable+wr_en, registered read with one cycle of latency.
  initial for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (ram_a_enb) begin
      if (ram_wr_en) mem[ram_addr] <= ram_data_in;
      else ram_dout_a <= mem[ram_addr];
    end
    if (ram_b_enb) begin
      if (ram_wr_en) mem[ram_addr] <= ram_data_in;
      else ram_dout_b <= mem[ram_addr];
    end
  end

  always @(negedge clk) begin
    b_enb_cnt    <= b_enb_cnt + int'(ram_b_enb);
    b_rvalid_cnt <= b_rvalid_cnt + int'(b_rvalid);
    both_ack_cnt <= both_ack_cnt + int'(a_ack && b_ack);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Raise a request and hold it until its ack, snapshotting the RAM bus in the ack cycle.
  task automatic applyStimulus(input logic client_b, input logic we, input logic [4:0] addr,
                               input logic [7:0] data, input string tag);
    if (client_b) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data;
    end
    got_ack = 1'b0;
    for (int i = 0; i < 10 && !got_ack; i++) begin
      step();
      if (client_b ? b_ack : a_ack) begin
        got_ack   = 1'b1;
        snap_addr = ram_addr;
        snap_data = ram_data_in;
        snap_wr   = ram_wr_en;
        snap_aenb = ram_a_enb;
        snap_benb = ram_b_enb;
        snap_oack = client_b ? a_ack : b_ack;
      end
    end
    if (client_b) b_req = 1'b0;
    else a_req = 1'b0;
    checkOutput({tag, "_ack"}, 32'(got_ack), 32'd1);
  endtask

  task automatic readCheck(input logic client_b, input string tag, input int lat, input logic [7:0] data);
    int k;
    k = 9;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (client_b ? b_rvalid : a_rvalid) begin
        k = i;
        break;
      end
    end
    checkOutput({tag, "_rvalid_lat"}, 32'(k), 32'(lat));
    checkOutput({tag, "_rdata"}, 32'(client_b ? b_rdata : a_rdata), 32'(data));
    step();
    checkOutput({tag, "_rvalid_pulse"}, 32'(client_b ? b_rvalid : a_rvalid), 32'd0);
  endtask

  initial begin
    int cnt0;
    int n;
    logic seq [8];

    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    rst = 1'b1;
    $display("[TB] reset");
    step(); step();
    checkOutput("rst_flags", 32'({a_ack, b_ack, a_rvalid, b_rvalid, ram_wr_en, ram_a_enb, ram_b_enb}), 32'd0);
    checkOutput("rst_a_rdata", 32'(a_rdata), 32'd0);
    checkOutput("rst_b_rdata", 32'(b_rdata), 32'd0);
    checkOutput("rst_ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("rst_ram_data", 32'(ram_data_in), 32'd0);
    rst = 1'b0;
    step();
    checkOutput("idle_flags", 32'({a_ack, b_ack, a_rvalid, b_rvalid, ram_wr_en, ram_a_enb, ram_b_enb}), 32'd0);

    $display("[TB] A write 5 <- AA");
    applyStimulus(1'b0, 1'b1, 5'd5, 8'hAA, "t2");
    checkOutput("t2_addr", 32'(snap_addr), 32'd5);
    checkOutput("t2_data", 32'(snap_data), 32'hAA);
    checkOutput("t2_wr_en", 32'(snap_wr), 32'd1);
    checkOutput("t2_a_enb", 32'(snap_aenb), 32'd1);
    checkOutput("t2_b_enb", 32'(snap_benb), 32'd0);
    checkOutput("t2_b_ack", 32'(snap_oack), 32'd0);
    step();
    checkOutput("t2_ack_once", 32'(a_ack), 32'd0);
    checkOutput("t2_wr_en_off", 32'(ram_wr_en), 32'd0);
    checkOutput("t2_addr_hold", 32'(ram_addr), 32'd5);

    $display("[TB] A read 5");
    cnt0 = b_enb_cnt;
    applyStimulus(1'b0, 1'b0, 5'd5, 8'h00, "t3");
    checkOutput("t3_wr_en", 32'(snap_wr), 32'd0);
    checkOutput("t3_a_enb", 32'(snap_aenb), 32'd1);
    readCheck(1'b0, "t3", 2, 8'hAA);
    checkOutput("t3_b_enb_cnt", 32'(b_enb_cnt - cnt0), 32'd0);
    step(); step();
    checkOutput("t3_rdata_hold", 32'(a_rdata), 32'hAA);

    $display("[TB] B write 5 <- CC, A read 5");
    cnt0 = b_enb_cnt;
    applyStimulus(1'b1, 1'b1, 5'd5, 8'hCC, "t4");
    checkOutput("t4_b_enb", 32'(snap_benb), 32'd1);
    checkOutput("t4_a_enb", 32'(snap_aenb), 32'd0);
    checkOutput("t4_data", 32'(snap_data), 32'hCC);
    step();
    applyStimulus(1'b0, 1'b0, 5'd5, 8'h00, "t4r");
    readCheck(1'b0, "t4", 2, 8'hCC);
    checkOutput("t4_b_enb_cnt", 32'(b_enb_cnt - cnt0), 32'd1);

    $display("[TB] both requests held");
    cnt0 = both_ack_cnt;
    n = 0;
    a_req = 1; a_we = 1; a_addr = 5'd10; a_wdata = 8'h11;
    b_req = 1; b_we = 1; b_addr = 5'd11; b_wdata = 8'h22;
    for (int i = 0; i < 24; i++) begin
      step();
      if (n < 8 && (a_ack ^ b_ack)) begin
        seq[n] = b_ack;
        n++;
      end
    end
    a_req = 0; b_req = 0;
    step(); step();
    checkOutput("t5_ack_count", 32'(n), 32'd8);
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("t5_ack_%0d_is_b", i), 32'(seq[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
    checkOutput("t5_both_ack", 32'(both_ack_cnt - cnt0), 32'd0);

    $display("[TB] reset during pending B read");
    cnt0 = b_rvalid_cnt;
    applyStimulus(1'b1, 1'b0, 5'd10, 8'h00, "t6");
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("t6_rst_a_rdata", 32'(a_rdata), 32'd0);
    checkOutput("t6_rst_flags", 32'({a_ack, b_ack, a_rvalid, b_rvalid, ram_wr_en, ram_a_enb, ram_b_enb}), 32'd0);
    for (int i = 0; i < 6; i++) step();
    checkOutput("t6_no_rvalid", 32'(b_rvalid_cnt - cnt0), 32'd0);
    applyStimulus(1'b1, 1'b0, 5'd11, 8'h00, "t6b");
    checkOutput("t6b_addr", 32'(snap_addr), 32'd11);
    readCheck(1'b1, "t6b", 2, 8'h22);
    checkOutput("t6b_rvalid_cnt", 32'(b_rvalid_cnt - cnt0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
